// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame geometry.
// Used by the receiver and, as it migrates, the transmitter.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_state_e;

   // States in which a frame is in flight (BREAK is deliberately excluded).
   function automatic logic is_busy_state(uart_state_e s);
      return (s == START) || (s == DATA) || (s == STOP);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line; resets to the idle level (1).
// Only compiled when UART_RX_SYNC_EN is defined, since only then is it instantiated.
`ifdef UART_RX_SYNC_EN
module uart_rx_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], d};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[1];

endmodule
`endif

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start confirmation at half a bit, then one sample per bit period.
// Define UART_RX_SYNC_EN to put a 2-flop synchroniser in front of the FSM (+2 cycles latency).
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_en,
   input  logic       rx_data_in,
   output logic [7:0] rx_data_out,
   output logic       start,
   output logic       busy,
   output logic       valid,
   output logic       frame_err,
   output logic [2:0] dbg_state
);

   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int CNT_W = ($clog2(CLKS_PER_BIT + 1) < 1) ? 1 : $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic             SKIP_START = (HALF == 0);

   logic line;

`ifdef UART_RX_SYNC_EN
   uart_rx_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rx_data_in),
      .q       (line)
   );
`else
   assign line = rx_data_in;
`endif

   uart_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 start_q, start_d;
   logic                 busy_q, busy_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      start_d   = 1'b0;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_en && !line) begin
               // With one clk per bit there is no half-bit to wait for.
               if (SKIP_START) begin
                  state_d   = DATA;
                  cnt_d     = '0;
                  bit_idx_d = '0;
                  start_d   = 1'b1;
               end else begin
                  state_d = START;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!line) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
                  start_d   = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               shift_d   = {line, shift_q[DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == LAST_BIT) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (line) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         BREAK: begin
            // A line held low must go high before another start is accepted.
            if (line) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            cnt_d     = '0;
            bit_idx_d = '0;
         end
      endcase

      busy_d = is_busy_state(state_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign rx_data_out = data_q;
   assign start       = start_q;
   assign busy        = busy_q;
   assign valid       = valid_q;
   assign frame_err   = ferr_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at 1 clk/bit and one at 16 clk/bit, with
// directed vectors, multi-cycle corner sequences and random frames against a frame-level model.
module tb_uart_rx;
   import uart_pkg::*;

`ifdef UART_RX_SYNC_EN
   localparam int SYNC_DLY = 2;
`else
   localparam int SYNC_DLY = 0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic       rx_en1, line1, start1, busy1, valid1, ferr1;
   logic [7:0] dout1;
   logic [2:0] dbg1;
   logic       rx_en16, line16, start16, busy16, valid16, ferr16;
   logic [7:0] dout16;
   logic [2:0] dbg16;

   uart_rx #(.CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .rx_en(rx_en1), .rx_data_in(line1),
      .rx_data_out(dout1), .start(start1), .busy(busy1), .valid(valid1),
      .frame_err(ferr1), .dbg_state(dbg1)
   );

   uart_rx #(.CLKS_PER_BIT(16)) dut16 (
      .clk(clk), .reset_n(reset_n), .rx_en(rx_en16), .rx_data_in(line16),
      .rx_data_out(dout16), .start(start16), .busy(busy16), .valid(valid16),
      .frame_err(ferr16), .dbg_state(dbg16)
   );

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // ---------------- scoreboard / monitors ----------------
   logic [7:0] exp_q1[$];
   logic [7:0] exp_q16[$];
   int n_valid1 = 0, n_start1 = 0, n_ferr1 = 0, n_busy1 = 0, last_valid_cyc1 = 0;
   int n_valid16 = 0, n_start16 = 0, n_ferr16 = 0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (valid1) begin
            n_valid1++;
            last_valid_cyc1 = cyc;
            if (exp_q1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb1_unexpected_valid: got byte 0x%0h, expected no valid", dout1);
            end else begin
               check("sb1_byte", int'(dout1), int'(exp_q1.pop_front()));
            end
         end
         if (start1) n_start1++;
         if (ferr1)  n_ferr1++;
         if (busy1)  n_busy1++;
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (valid16) begin
            n_valid16++;
            if (exp_q16.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb16_unexpected_valid: got byte 0x%0h, expected no valid", dout16);
            end else begin
               check("sb16_byte", int'(dout16), int'(exp_q16.pop_front()));
            end
         end
         if (start16) n_start16++;
         if (ferr16)  n_ferr16++;
      end
   end

   // ---------------- frame-level reference model ----------------
   logic [7:0] good1 = 8'h00, good16 = 8'h00;
   int m_valid1 = 0, m_start1 = 0, m_ferr1 = 0;
   int m_valid16 = 0, m_start16 = 0, m_ferr16 = 0;

   task automatic model_frame(input int sel, input logic [7:0] data, input logic stop, input logic en);
      if (en) begin
         if (sel == 0) begin
            m_start1++;
            if (stop) begin
               m_valid1++;
               good1 = data;
               exp_q1.push_back(data);
            end else begin
               m_ferr1++;
            end
         end else begin
            m_start16++;
            if (stop) begin
               m_valid16++;
               good16 = data;
               exp_q16.push_back(data);
            end else begin
               m_ferr16++;
            end
         end
      end
   endtask

   // ---------------- drivers ----------------
   int t_start = 0;

   task automatic drive_bit(input int sel, input logic b);
      if (sel == 0) begin
         line1 = b;
         @(negedge clk);
      end else begin
         line16 = b;
         repeat (16) @(negedge clk);
      end
   endtask

   task automatic send_frame(input int sel, input logic [7:0] data, input logic stop);
      t_start = cyc;
      drive_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
      drive_bit(sel, stop);
   endtask

   task automatic idle(input int sel, input int n);
      if (sel == 0) line1 = 1'b1;
      else line16 = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic       en;
      logic [7:0] d0;
      logic       s0;
      logic       two;
      logic [7:0] d1;
      int         e_valid;
      int         e_ferr;
      int         e_start;
      int         e_busy;
      logic [7:0] e_dout;
   } vec_t;

   vec_t vt[6];

   initial begin
      int sv, sf, ss, sb;
      vt[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1, 0, 1,  9, 8'hA5};
      vt[1] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'hFF, 2, 0, 2, 18, 8'hFF};
      vt[2] = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 0, 1, 1,  9, 8'hFF};
      vt[3] = '{1'b1, 8'h81, 1'b1, 1'b0, 8'h00, 1, 0, 1,  9, 8'h81};
      vt[4] = '{1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 0, 0, 0,  0, 8'h81};
      vt[5] = '{1'b1, 8'h7E, 1'b1, 1'b0, 8'h00, 1, 0, 1,  9, 8'h7E};

      // reset state
      reset_n = 1'b0;
      rx_en1 = 1'b0; line1 = 1'b1;
      rx_en16 = 1'b0; line16 = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_dout1", int'(dout1), 0);
      check("rst_flags1", int'({start1, busy1, valid1, ferr1}), 0);
      check("rst_state1", int'(dbg1), int'(IDLE));
      check("rst_dout16", int'(dout16), 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_flags1", int'({start1, busy1, valid1, ferr1}), 0);
      check("post_rst_flags16", int'({start16, busy16, valid16, ferr16}), 0);

      // table-driven single/back-to-back/error/disabled frames
      for (int i = 0; i < 6; i++) begin
         sv = n_valid1; sf = n_ferr1; ss = n_start1; sb = n_busy1;
         rx_en1 = vt[i].en;
         model_frame(0, vt[i].d0, vt[i].s0, vt[i].en);
         if (vt[i].two) model_frame(0, vt[i].d1, 1'b1, vt[i].en);
         send_frame(0, vt[i].d0, vt[i].s0);
         if (vt[i].two) send_frame(0, vt[i].d1, 1'b1);
         idle(0, 6);
         check($sformatf("vec%0d_valid", i), n_valid1 - sv, vt[i].e_valid);
         check($sformatf("vec%0d_ferr", i), n_ferr1 - sf, vt[i].e_ferr);
         check($sformatf("vec%0d_start", i), n_start1 - ss, vt[i].e_start);
         check($sformatf("vec%0d_busy_cycles", i), n_busy1 - sb, vt[i].e_busy);
         check($sformatf("vec%0d_dout", i), int'(dout1), int'(vt[i].e_dout));
         rx_en1 = 1'b1;
      end

      // latency: valid is seen 10 cycles after the start bit is driven (+2 with synchroniser)
      model_frame(0, 8'hA5, 1'b1, 1'b1);
      send_frame(0, 8'hA5, 1'b1);
      idle(0, 6);
      check("latency_a5", last_valid_cyc1 - t_start, 10 + SYNC_DLY);
      check("latency_a5_dout", int'(dout1), 8'hA5);

      // stop bit forced low, line held low: stays in BREAK, no restart
      sv = n_valid1; sf = n_ferr1; ss = n_start1;
      model_frame(0, 8'h3C, 1'b0, 1'b1);
      send_frame(0, 8'h3C, 1'b0);
      line1 = 1'b0;
      repeat (20) @(negedge clk);
      check("brk_state", int'(dbg1), int'(BREAK));
      check("brk_busy", int'(busy1), 0);
      check("brk_ferr", n_ferr1 - sf, 1);
      check("brk_no_valid", n_valid1 - sv, 0);
      check("brk_no_restart", n_start1 - ss, 1);
      check("brk_dout_kept", int'(dout1), 8'hA5);
      idle(0, 4);
      check("brk_exit_state", int'(dbg1), int'(IDLE));
      model_frame(0, 8'h81, 1'b1, 1'b1);
      send_frame(0, 8'h81, 1'b1);
      idle(0, 6);
      check("brk_next_dout", int'(dout1), 8'h81);

      // reset during data bit 4 discards the partial byte
      sv = n_valid1;
      line1 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
      m_start1++;  // start confirmed before the reset arrives
      line1 = 1'b0;
      #2;
      check("midrst_busy_before", int'(busy1), 1);
      reset_n = 1'b0;
      #1;
      check("midrst_dout", int'(dout1), 0);
      check("midrst_flags", int'({start1, busy1, valid1, ferr1}), 0);
      check("midrst_state", int'(dbg1), int'(IDLE));
      good1 = 8'h00;
      good16 = 8'h00;
      line1 = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      idle(0, 3);
      check("midrst_no_valid", n_valid1 - sv, 0);
      model_frame(0, 8'hC3, 1'b1, 1'b1);
      send_frame(0, 8'hC3, 1'b1);
      idle(0, 6);
      check("midrst_next_dout", int'(dout1), 8'hC3);
      check("midrst_next_valid", n_valid1 - sv, 1);

      // 16 clk/bit: short low glitch is rejected, then a full frame
      rx_en16 = 1'b1;
      line16 = 1'b0;
      repeat (3) @(negedge clk);
      line16 = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch16_start", n_start16, 0);
      check("glitch16_valid", n_valid16, 0);
      check("glitch16_state", int'(dbg16), int'(IDLE));
      check("glitch16_busy", int'(busy16), 0);
      model_frame(1, 8'h5A, 1'b1, 1'b1);
      send_frame(1, 8'h5A, 1'b1);
      idle(1, 20);
      check("frame16_dout", int'(dout16), 8'h5A);
      check("frame16_valid", n_valid16, 1);
      check("frame16_start", n_start16, 1);

      // random frames, 1 clk/bit
      for (int i = 0; i < 40; i++) begin
         logic [7:0] d;
         logic       s, en;
         int         gap;
         d   = 8'($urandom_range(0, 255));
         s   = ($urandom_range(0, 4) != 0);
         en  = ($urandom_range(0, 7) != 0);
         gap = $urandom_range(0, 3);
         if (!s && gap < 1) gap = 1;
         if (!en && gap < 3) gap = 3;
         rx_en1 = en;
         model_frame(0, d, s, en);
         send_frame(0, d, s);
         idle(0, gap);
      end
      rx_en1 = 1'b1;
      idle(0, 8);

      // random frames, 16 clk/bit
      for (int i = 0; i < 6; i++) begin
         logic [7:0] d;
         logic       s;
         d = 8'($urandom_range(0, 255));
         s = ($urandom_range(0, 3) != 0);
         model_frame(1, d, s, 1'b1);
         send_frame(1, d, s);
         idle(1, $urandom_range(1, 5));
      end
      idle(1, 20);

      // totals against the model
      check("tot_valid1", n_valid1, m_valid1);
      check("tot_ferr1", n_ferr1, m_ferr1);
      check("tot_start1", n_start1, m_start1);
      check("final_dout1", int'(dout1), int'(good1));
      check("sb1_drained", exp_q1.size(), 0);
      check("tot_valid16", n_valid16, m_valid16);
      check("tot_ferr16", n_ferr16, m_ferr16);
      check("tot_start16", n_start16, m_start16);
      check("final_dout16", int'(dout16), int'(good16));
      check("sb16_drained", exp_q16.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
